fosfor_present_host: RTL
========================

FOSFOR_PRESENT_HOST -- requirements
Module: fosfor_present_host

Interface
REQ-001 SHALL have parameter BUS_W, default 4: host data bus width, legal values 4 or 8.
REQ-002 SHALL have parameter KEY_W, default 80: cipher key width, legal values 80 or 128.
REQ-003 Clk_ik  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset_ir  input  1  asynchronous, active-high reset.
REQ-005 Addr_ib  input  2  host access type: 00 idle/status, 01 command, 10 data chunk 0, 11 data chunk 1.
REQ-006 Data_ib  input  BUS_W  host write data.
REQ-007 Data_ob  output  8  registered host read data.
REQ-008 PlainText_ob  output  64  plaintext to cipher core.
REQ-009 Key_ob  output  KEY_W  key to cipher core.
REQ-010 Start_o  output  1  one-cycle start pulse to core.
REQ-011 Ready_i  input  1  core idle/ready flag.
REQ-012 CipherText_ib  input  64  core ciphertext, valid when Ready_i is high after a run.

Function
REQ-013 Staging byte SHALL be: BUS_W=4: Addr 10 writes bits 3:0, Addr 11 writes bits 7:4; BUS_W=8: Addr 10 writes the full byte, Addr 11 is a no-op.
REQ-014 Addr 01 SHALL load the self-clearing command register; bits: 0 latch address, 1 read, 2 write, 3 start; the command executes on the next edge, then clears.
REQ-015 With latch set, read/write in the same command SHALL use the newly latched address (staging byte).
REQ-016 Value 0xF (all bits) SHALL perform only "clear error"; no latch/read/write/start.
REQ-017 Address map: 0x00-0x07 plaintext byte n (write) / result byte n (read); 0x08 test register (r/w); 0x10 to 0x10+KEY_W/8-1 key byte n, write-only.
REQ-018 Reads of unmapped or write-only addresses SHALL load 0x00; writes to unmapped addresses SHALL be ignored.
REQ-019 Data_ob SHALL register, each edge, status when Addr_ib[1]=0 and read-data register when Addr_ib[1]=1.
REQ-020 Status byte SHALL be {4'b0, err, done, busy, Ready_i}.
REQ-021 FSM states: IDLE, WAIT_LOW, RUN.
REQ-022 IDLE: start command with Ready_i=1 -> Start_o high one cycle, done cleared, -> WAIT_LOW.
REQ-023 WAIT_LOW: Ready_i=0 -> RUN; RUN: Ready_i=1 -> capture CipherText_ib into 64-bit result register, set done, -> IDLE.
REQ-024 busy SHALL be 1 in WAIT_LOW and RUN.
REQ-025 Start command while busy or Ready_i=0 SHALL be ignored and set err.
REQ-026 Plaintext/key writes while busy SHALL be ignored and set err; test register and result reads remain allowed.
REQ-027 Result register SHALL only change at capture, so reads are stable during a run.
REQ-028 Latency: command sampled at edge E; action at E+1; read data on Data_ob after edge E+2 with Addr_ib[1]=1.
REQ-029 done and err are sticky; done clears only on accepted start, err only on 0xF.

Reset
REQ-030 Reset_ir high SHALL immediately force: FSM IDLE, Start_o 0, Data_ob 0x00, command/staging/address/test/result registers 0, PlainText_ob 0, Key_ob 0, done 0, err 0.
REQ-031 Reset during WAIT_LOW or RUN SHALL abandon the run; no capture, done stays 0.

Configuration
REQ-032 Macro FOSFOR_AUTOINC_EN defined: after each executed read or write command the address register increments by 1, wrapping 0xFF -> 0x00 (after latch if both).
REQ-033 FOSFOR_AUTOINC_EN undefined: address changes only on latch.

Verification
REQ-034 Reset, then Addr 00 -> Data_ob 0x01 with Ready_i=1, all core outputs 0.
REQ-035 Write 0xA5 to 0x08 (nibbles 5, A; latch; write), read back -> Data_ob 0xA5.
REQ-036 Load plaintext 0x0, key 0x0 (KEY_W=80), start, model core returns 0x5579C1387B228445 -> done=1, bytes 0x00..0x07 read 0x45,0x84,0x22,0x7B,0x38,0xC1,0x79,0x55.
REQ-037 Start again during RUN, plus key write -> err=1, Key_ob unchanged; command 0xF -> err=0.
REQ-038 With FOSFOR_AUTOINC_EN, latch 0xFF, two writes 0x11, 0x22 -> writes to 0xFF ignored, 0x00 gets 0x22 (address wrapped).
REQ-039 Reset_ir asserted in RUN -> Start_o 0, busy 0, done 0 immediately; result stays 0.

Source files
------------

// File: rtl/fosfor_present_host.sv
// Host-side register front end for a PRESENT-style cipher core: nibble/byte staging,
// self-clearing command register, address-mapped plaintext/key/result access and a run FSM.
// Optional build macro FOSFOR_AUTOINC_EN: address register post-increments after read/write commands.
module fosfor_present_host #(
    parameter int BUS_W = 4,
    parameter int KEY_W = 80
) (
    input  logic               Clk_ik,
    input  logic               Reset_ir,
    input  logic [1:0]         Addr_ib,
    input  logic [BUS_W-1:0]   Data_ib,
    output logic [7:0]         Data_ob,
    output logic [63:0]        PlainText_ob,
    output logic [KEY_W-1:0]   Key_ob,
    output logic               Start_o,
    input  logic               Ready_i,
    input  logic [63:0]        CipherText_ib
);

    localparam int KEY_BYTES = KEY_W / 8;

    typedef enum logic [1:0] {IDLE, WAIT_LOW, RUN} state_t;

    state_t      state, next_state;
    logic [3:0]  cmd;
    logic [7:0]  stage, addr, test_reg, rd_data;
    logic [63:0] result;
    logic        done, err;

    logic [7:0]  data_byte, eff_addr, rd_mux;
    logic        clr_cmd, do_latch, do_read, do_write, start_cmd;
    logic        busy, prot_hit, prot_err;
    logic        start_ok, start_bad, capture;

    assign data_byte = 8'(Data_ib);

    // 0xF is reserved for "clear error" and suppresses every other command bit.
    assign clr_cmd   = (cmd == 4'hF);
    assign do_latch  = cmd[0] && !clr_cmd;
    assign do_read   = cmd[1] && !clr_cmd;
    assign do_write  = cmd[2] && !clr_cmd;
    assign start_cmd = cmd[3] && !clr_cmd;

    assign eff_addr = do_latch ? stage : addr;
    assign busy     = (state != IDLE);
    assign prot_hit = (eff_addr < 8'h08) ||
                      (eff_addr >= 8'h10 && eff_addr < 8'(16 + KEY_BYTES));
    assign prot_err = do_write && busy && prot_hit;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_mux = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (eff_addr == 8'(i)) rd_mux = result[8*i +: 8];
        end
        if (eff_addr == 8'h08) rd_mux = test_reg;
    end

    always_comb begin
        next_state = state;
        start_ok   = 1'b0;
        start_bad  = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start_cmd) begin
                    if (Ready_i) begin
                        start_ok   = 1'b1;
                        next_state = WAIT_LOW;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            WAIT_LOW: begin
                start_bad = start_cmd;
                if (!Ready_i) next_state = RUN;
            end
            RUN: begin
                start_bad = start_cmd;
                if (Ready_i) begin
                    capture    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk_ik or posedge Reset_ir) begin
        if (Reset_ir) state <= IDLE;
        else          state <= next_state;
    end

    always_ff @(posedge Clk_ik or posedge Reset_ir) begin
        if (Reset_ir) begin
            cmd          <= 4'h0;
            stage        <= 8'h00;
            addr         <= 8'h00;
            test_reg     <= 8'h00;
            rd_data      <= 8'h00;
            result       <= 64'h0;
            PlainText_ob <= 64'h0;
            Key_ob       <= '0;
            Start_o      <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            Data_ob      <= 8'h00;
        end else begin
            // Command register holds a value for exactly one cycle: it executes on the following edge.
            cmd <= (Addr_ib == 2'b01) ? data_byte[3:0] : 4'h0;

            if (Addr_ib == 2'b10) begin
                if (BUS_W == 8) stage      <= data_byte;
                else            stage[3:0] <= data_byte[3:0];
            end
            if (Addr_ib == 2'b11 && BUS_W == 4) stage[7:4] <= data_byte[3:0];

            if (do_latch) addr <= stage;
`ifdef FOSFOR_AUTOINC_EN
            if (do_read || do_write) addr <= eff_addr + 8'd1;
`endif

            if (do_read) rd_data <= rd_mux;

            if (do_write) begin
                if (eff_addr == 8'h08) test_reg <= stage;
                if (!busy) begin
                    for (int i = 0; i < 8; i++) begin
                        if (eff_addr == 8'(i)) PlainText_ob[8*i +: 8] <= stage;
                    end
                    for (int i = 0; i < KEY_BYTES; i++) begin
                        if (eff_addr == 8'(16 + i)) Key_ob[8*i +: 8] <= stage;
                    end
                end
            end

            Start_o <= start_ok;
            if (start_ok)     done <= 1'b0;
            else if (capture) done <= 1'b1;

            if (clr_cmd)                     err <= 1'b0;
            else if (start_bad || prot_err) err <= 1'b1;

            if (capture) result <= CipherText_ib;

            Data_ob <= Addr_ib[1] ? rd_data : {4'b0, err, done, busy, Ready_i};
        end
    end

endmodule
